// File: rtl/dmem_sized.sv
// Byte-addressable little-endian data memory serving sized MIPS loads/stores
// over a valid/ready port, with fixed-latency pipelined responses and a post-reset clear.
module dmem_sized #(
  parameter int    ADDR_WIDTH   = 10,
  parameter int    READ_LATENCY = 1,
  parameter string INIT_FILE    = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);
  localparam int  BYTES    = 1 << ADDR_WIDTH;
  localparam int  WORDS    = BYTES / 4;
  localparam int  CW       = (ADDR_WIDTH > 2) ? ADDR_WIDTH - 2 : 1;
  localparam bit  HAS_INIT = (INIT_FILE != "");

  typedef enum logic {CLEAR, RUN} state_t;

  state_t                state, state_nxt;
  logic [CW-1:0]         clr_idx;
  logic                  ready;
  logic [7:0]            mem [BYTES];

  logic [ADDR_WIDTH-1:0] ba, wbase, cbase;
  logic [1:0]            lane;
  logic                  acc, err, wr;
  logic [31:0]           rword, ld, rdata0, wlane;
  logic [7:0]            rb;
  logic [15:0]           rh;
  logic [3:0]            be;

  logic [READ_LATENCY:1]        vld_pipe;
  logic [READ_LATENCY:1]        err_pipe;
  logic [READ_LATENCY:1][31:0]  data_pipe;

  always_comb begin
    state_nxt = state;
    case (state)
      CLEAR: if (clr_idx == CW'(WORDS - 1)) state_nxt = RUN;
      RUN:   state_nxt = RUN;
      default: state_nxt = CLEAR;
    endcase
  end

  // ready is registered so it stays low through reset even when no clear is needed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= HAS_INIT ? RUN : CLEAR;
      clr_idx <= '0;
      ready   <= 1'b0;
    end else begin
      state <= state_nxt;
      ready <= (state_nxt == RUN);
      if (state == CLEAR) clr_idx <= clr_idx + 1'b1;
    end
  end

  assign req_ready = ready;
  assign acc       = req_valid & ready;

  always_comb begin
    ba     = req_addr[ADDR_WIDTH-1:0];
    lane   = req_addr[1:0];
    wbase  = ba & ~ADDR_WIDTH'(3);
    cbase  = ADDR_WIDTH'({clr_idx, 2'b00});
    err    = (|req_addr[31:ADDR_WIDTH]) | (req_size == 2'd3) |
             ((req_size == 2'd1) & ba[0]) | ((req_size == 2'd2) & (|ba[1:0]));
    rword  = {mem[wbase | ADDR_WIDTH'(3)], mem[wbase | ADDR_WIDTH'(2)],
              mem[wbase | ADDR_WIDTH'(1)], mem[wbase]};
    rb     = rword[8*lane +: 8];
    rh     = ba[1] ? rword[31:16] : rword[15:0];
    case (req_size)
      2'd0:    ld = {{24{req_signed & rb[7]}}, rb};
      2'd1:    ld = {{16{req_signed & rh[15]}}, rh};
      default: ld = rword;
    endcase
    rdata0 = (err | req_we) ? 32'h0 : ld;
    // store data is replicated so each enabled lane just takes its own byte
    case (req_size)
      2'd0:    begin be = 4'b0001 << lane;                    wlane = {4{req_wdata[7:0]}};  end
      2'd1:    begin be = ba[1] ? 4'b1100 : 4'b0011;          wlane = {2{req_wdata[15:0]}}; end
      2'd2:    begin be = 4'b1111;                            wlane = req_wdata;            end
      default: begin be = 4'b0000;                            wlane = req_wdata;            end
    endcase
    wr = acc & req_we & ~err;
  end

  always_ff @(posedge clk) begin
    if (state == CLEAR && !rst) begin
      for (int j = 0; j < 4; j++) mem[cbase | ADDR_WIDTH'(j)] <= 8'h00;
    end else if (wr) begin
      for (int j = 0; j < 4; j++)
        if (be[j]) mem[wbase | ADDR_WIDTH'(j)] <= wlane[8*j +: 8];
    end
  end

  // data/err only advance with a valid entry, so the last stage holds between responses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe  <= '0;
      err_pipe  <= '0;
      data_pipe <= '0;
    end else begin
      vld_pipe[1] <= acc;
      if (acc) begin
        data_pipe[1] <= rdata0;
        err_pipe[1]  <= err;
      end
      for (int i = 2; i <= READ_LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        if (vld_pipe[i-1]) begin
          data_pipe[i] <= data_pipe[i-1];
          err_pipe[i]  <= err_pipe[i-1];
        end
      end
    end
  end

  assign resp_valid = vld_pipe[READ_LATENCY];
  assign resp_rdata = data_pipe[READ_LATENCY];
  assign resp_err   = err_pipe[READ_LATENCY];

endmodule

// File: tb/tb_dmem_sized.sv
// Directed bench for dmem_sized: clear timing, sized accesses, faults,
// latency/throughput and reset during traffic and during clear.
module tb_dmem_sized;
  localparam int AW = 10;
  localparam int RL = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int n_chk = 0;
  int n_err = 0;
  int pulses = 0;
  logic mon = 1'b0;

  dmem_sized #(.ADDR_WIDTH(AW), .READ_LATENCY(RL), .INIT_FILE("")) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (mon && resp_valid) pulses++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd);
    req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
  endtask

  // one request, then wait for its response; n counts cycles after the request cycle
  task automatic xfer(input string tag, input logic we, input logic [1:0] sz, input logic sg,
                      input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] exp_d, input logic exp_e);
    int n;
    @(negedge clk);
    drive(we, sz, sg, a, wd);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    n = 1;
    while (!resp_valid && n < 12) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_lat"}, n, RL);
    check({tag, "_data"}, resp_rdata, exp_d);
    check({tag, "_err"}, {31'h0, resp_err}, {31'h0, exp_e});
  endtask

  task automatic wait_ready(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk);
      cyc++;
      #1;
    end while (!req_ready && cyc < 400);
  endtask

  logic        v_s [1:6];
  logic [31:0] d_s [1:6];

  initial begin
    int cyc;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {31'h0, req_ready}, 32'h0);
    check("rst_valid", {31'h0, resp_valid}, 32'h0);
    check("rst_rdata", resp_rdata, 32'h0);
    check("rst_err",   {31'h0, resp_err}, 32'h0);

    @(negedge clk); rst = 1'b0;
    wait_ready(cyc);
    check("clear_cycles", cyc, 256);

    xfer("lw_3fc", 1'b0, 2'd2, 1'b0, 32'h3FC, 32'h0, 32'h0, 1'b0);

    xfer("sw_10",  1'b1, 2'd2, 1'b0, 32'h10, 32'h80F1A2B3, 32'h0, 1'b0);
    xfer("lb_10",  1'b0, 2'd0, 1'b1, 32'h10, 32'h0, 32'hFFFFFFB3, 1'b0);
    xfer("lbu_13", 1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 32'h00000080, 1'b0);
    xfer("lh_12",  1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 32'hFFFF80F1, 1'b0);
    xfer("lhu_10", 1'b0, 2'd1, 1'b0, 32'h10, 32'h0, 32'h0000A2B3, 1'b0);
    xfer("lw_10a", 1'b0, 2'd2, 1'b1, 32'h10, 32'h0, 32'h80F1A2B3, 1'b0);

    xfer("sb_11",  1'b1, 2'd0, 1'b0, 32'h11, 32'hFFFFFF5A, 32'h0, 1'b0);
    xfer("lw_10b", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'h80F15AB3, 1'b0);
    xfer("lw_14",  1'b0, 2'd2, 1'b0, 32'h14, 32'h0, 32'h00000000, 1'b0);

    xfer("lw_02",  1'b0, 2'd2, 1'b0, 32'h02, 32'h0, 32'h0, 1'b1);
    xfer("lh_05",  1'b0, 2'd1, 1'b1, 32'h05, 32'h0, 32'h0, 1'b1);
    xfer("sz3_00", 1'b1, 2'd3, 1'b0, 32'h00, 32'hCAFEF00D, 32'h0, 1'b1);
    xfer("sw_400", 1'b1, 2'd2, 1'b0, 32'h400, 32'h12345678, 32'h0, 1'b1);
    xfer("lw_00",  1'b0, 2'd2, 1'b0, 32'h00, 32'h0, 32'h00000000, 1'b0);
    xfer("sw_12",  1'b1, 2'd2, 1'b0, 32'h12, 32'h11223344, 32'h0, 1'b1);
    xfer("sh_11",  1'b1, 2'd1, 1'b0, 32'h11, 32'h00007777, 32'h0, 1'b1);
    xfer("lw_10c", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'h80F15AB3, 1'b0);
    xfer("lb_hi",  1'b0, 2'd0, 1'b0, 32'h80000010, 32'h0, 32'h0, 1'b1);

    // back-to-back store then load of the same word
    @(negedge clk); drive(1'b1, 2'd2, 1'b0, 32'h20, 32'hDEADBEEF);
    @(posedge clk);
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      v_s[n] = resp_valid; d_s[n] = resp_rdata;
      if (n == 1) drive(1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
      if (n == 2) req_valid = 1'b0;
    end
    check("b2b_v2", {31'h0, v_s[2]}, 32'h0);
    check("b2b_v3", {31'h0, v_s[3]}, 32'h1);
    check("b2b_d3", d_s[3], 32'h0);
    check("b2b_v4", {31'h0, v_s[4]}, 32'h1);
    check("b2b_d4", d_s[4], 32'hDEADBEEF);
    check("b2b_v5", {31'h0, v_s[5]}, 32'h0);

    // reset with two loads in flight, then again in the middle of the clear
    @(negedge clk); drive(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    @(negedge clk); drive(1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
    @(negedge clk); req_valid = 1'b0; mon = 1'b1; rst = 1'b1;
    #1;
    check("mid_rst_ready", {31'h0, req_ready}, 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    check("mid_clear_ready", {31'h0, req_ready}, 32'h0);
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_ready(cyc);
    check("reclear_cycles", cyc, 256);
    @(negedge clk); mon = 1'b0;
    check("rst_pulses", pulses, 0);
    xfer("lw_20_clr", 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 32'h00000000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/dmem_sized.md
Name: dmem_sized

Overview:
Parametrised, byte-addressable, little-endian data memory that serves MIPS-style sized loads and stores (byte/half/word, signed or unsigned) over a valid/ready request port. Responses are pipelined with a configurable fixed latency. Out-of-range, misaligned and illegal-size accesses are flagged instead of silently wrapping. A post-reset clear sequencer zeroes the array unless an init file is supplied. Sits between the CPU MEM stage and the data array, replacing the plain word-only data memory.

Parameters:
ADDR_WIDTH, 10, byte-address bits decoded; capacity 2^ADDR_WIDTH bytes (legal range 2..20).
READ_LATENCY, 1, cycles from request acceptance to resp_valid (legal range 1..4).
INIT_FILE, "", hex byte image loaded at time 0; when non-empty, the post-reset clear is skipped.

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous reset, active-high
req_valid  in  1  request present
req_ready  out  1  block can accept a request this cycle
req_we  in  1  1 = store, 0 = load
req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal
req_signed  in  1  load sign-extends when 1; ignored for word and for stores
req_addr  in  32  byte address
req_wdata  in  32  store data, right-justified (byte in [7:0], half in [15:0])
resp_valid  out  1  response strobe, one cycle per accepted request
resp_rdata  out  32  load result, extended to 32 bits; 0 for stores and errors
resp_err  out  1  accepted request was faulty; no memory side effect

Behaviour:
- Reset, asynchronous: req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0. All in-flight pipeline entries are discarded. Array contents are not reset.
- FSM states:
  - CLEAR: entered on reset release when INIT_FILE is empty. Writes 32'h0 to one aligned word per cycle, walking from word 0 to 2^(ADDR_WIDTH-2)-1. req_ready=0. Goes to RUN after the last word.
  - RUN: entered directly on reset release when INIT_FILE is non-empty. req_ready=1 every cycle; there is no response backpressure.
  - Reset asserted mid-CLEAR restarts the clear from word 0.
- Acceptance: a request is accepted on a rising edge where req_valid and req_ready are both 1. One request is accepted per cycle at most.
- Error (resp_err=1) on any of:
  - req_addr[31:ADDR_WIDTH] is non-zero;
  - req_size==3;
  - half access with addr[0]=1;
  - word access with addr[1:0]!=0.
  An errored store writes nothing. An errored load returns 0.
- Store: committed at the acceptance edge, byte lanes little-endian (addr+0 gets the least significant byte). Only the 1, 2 or 4 addressed bytes change.
- Load: memory is sampled at the acceptance edge. A load accepted the cycle after a store to the same bytes returns the new data. Byte and half loads zero- or sign-extend per req_signed.
- Response: resp_valid, resp_rdata and resp_err are registered and appear exactly READ_LATENCY cycles after acceptance, in order. They hold their values until the next response. Stores also produce a response, with resp_rdata=0.
- Back-to-back requests yield back-to-back responses with full throughput.

Test Plan:
- Clear: ADDR_WIDTH=10, INIT_FILE empty, release rst -> req_ready rises exactly 256 cycles later; word load at 0x3FC returns 0x00000000.
- Sized store/load: sw 0x80F1A2B3 @0x10; then lb @0x10 -> 0xFFFFFFB3; lbu @0x13 -> 0x00000080; lh @0x12 -> 0xFFFF80F1; lhu @0x10 -> 0x0000A2B3.
- Partial store: sb 0x5A @0x11 over the word above, then lw @0x10 -> 0x80F15AB3; neighbouring word @0x14 unchanged.
- Faults: lw @0x02, lh @0x05, size=3 @0x00, sw @0x400 -> each resp_err=1 and resp_rdata=0; a following lw of the targeted word shows it unchanged.
- Latency/throughput: READ_LATENCY=3, issue sw@0x20 then lw@0x20 on consecutive cycles -> responses 3 and 4 cycles after the first acceptance, and the load returns the stored value.
- Reset mid-flight: assert rst while 2 loads are in flight and during CLEAR -> no resp_valid pulses after reset; after release, CLEAR restarts and req_ready=0 for the full 256 cycles.
